// File: rtl/grid_scan_driver.sv
//==============================================================================
// Module      : grid_scan_driver
// Description : Serialises a 2x8 LED grid into a 74HC595-style chain and
//               multiplexes the two rows. Option macro: DISP_ACTIVE_LOW_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module grid_scan_driver #(
    parameter int CLK_DIV = 2,
    parameter int DWELL   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] grid,
    output logic        sr_clk,
    output logic        sr_data,
    output logic        sr_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam int CNT_MAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] C_DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_DWELL_LAST = CW'(DWELL - 1);
    localparam logic [3:0]    C_TOP_BIT    = 4'd9;

`ifdef DISP_ACTIVE_LOW_EN
    // Common-anode panel: every data bit and the idle level are inverted
    localparam logic C_INV = 1'b1;
`else
    localparam logic C_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_row,   w_row_nxt;
    logic [3:0]    r_bit,   w_bit_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_high,  w_high_nxt;
    logic [15:0]   r_snap,  w_snap_nxt;
    logic [9:0]    w_word;

    assign w_word = r_row ? {2'b10, r_snap[15:8]} : {2'b01, r_snap[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_row   <= 1'b0;
            r_bit   <= 4'd0;
            r_cnt   <= '0;
            r_high  <= 1'b0;
            r_snap  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_bit   <= w_bit_nxt;
            r_cnt   <= w_cnt_nxt;
            r_high  <= w_high_nxt;
            r_snap  <= w_snap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_bit_nxt   = r_bit;
        w_cnt_nxt   = r_cnt;
        w_high_nxt  = r_high;
        w_snap_nxt  = r_snap;
        sr_clk      = 1'b0;
        sr_data     = C_INV;
        sr_latch    = 1'b0;
        frame_done  = 1'b0;
        busy        = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_snap_nxt  = grid;
                    w_row_nxt   = 1'b0;
                    w_bit_nxt   = C_TOP_BIT;
                    w_cnt_nxt   = '0;
                    w_high_nxt  = 1'b0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_clk  = r_high;
                sr_data = w_word[r_bit] ^ C_INV;
                if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_high) begin
                        w_high_nxt = 1'b1;
                    end else begin
                        // Bit index only advances as the clock falls
                        w_high_nxt = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_state_nxt = ST_LATCH;
                        end else begin
                            w_bit_nxt = r_bit - 4'd1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_LATCH: begin
                sr_latch = 1'b1;
                if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DWELL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DWELL: begin
                if (r_cnt == C_DWELL_LAST) begin
                    w_cnt_nxt  = '0;
                    w_high_nxt = 1'b0;
                    w_bit_nxt  = C_TOP_BIT;
                    if (!r_row) begin
                        w_row_nxt   = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        frame_done = 1'b1;
                        w_row_nxt  = 1'b0;
                        if (en) begin
                            w_snap_nxt  = grid;
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
